// File: rtl/dump_streamer_pkg.sv
// rtl/dump_streamer_pkg.sv - shared constants and FSM encoding for the debug dump streamer
package dump_streamer_pkg;

    localparam int CS_W      = 3;
    localparam int POS_W     = 5;
    localparam int NUM_CHIPS = 5;
    localparam int DEPTH     = 32;
    localparam int TIMEOUT   = 15;

    localparam logic [7:0] HDR_BASE     = 8'hA0;
    localparam logic [7:0] TIMEOUT_BYTE = 8'hFF;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR,
        ST_ADDR,
        ST_READ,
        ST_SEND,
        ST_GUARD,
        ST_TXWAIT,
        ST_NEXT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/dump_streamer.sv
// rtl/dump_streamer.sv - walks every chip/position of the CPU dump port and streams
// a header byte plus DEPTH data bytes per chip into the UART transmitter
module dump_streamer
    import dump_streamer_pkg::*;
#(
    parameter int P_CS_W      = CS_W,
    parameter int P_POS_W     = POS_W,
    parameter int P_NUM_CHIPS = NUM_CHIPS,
    parameter int P_DEPTH     = DEPTH,
    parameter int P_TIMEOUT   = TIMEOUT
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_start,
    output logic [P_CS_W-1:0]  o_cs,
    output logic [P_POS_W-1:0] o_pos,
    input  logic [7:0]         i_dmp_data,
    input  logic               i_dmp_valid,
    output logic               o_tx_wr,
    output logic [7:0]         o_tx_data,
    input  logic               i_tx_busy,
    output logic               o_active,
    output logic               o_done
);

    localparam int TW = $clog2(P_TIMEOUT + 1);

    localparam logic [TW-1:0]      TMO_LAST = TW'(P_TIMEOUT - 1);
    localparam logic [P_CS_W-1:0]  CS_LAST  = P_CS_W'(P_NUM_CHIPS - 1);
    localparam logic [P_POS_W-1:0] POS_LAST = P_POS_W'(P_DEPTH - 1);

    state_t             r_state;
    logic [P_CS_W-1:0]  r_cs;
    logic [P_POS_W-1:0] r_pos;
    logic [TW-1:0]      r_tmo;
    logic               r_is_hdr;
    logic [P_CS_W-1:0]  r_cs_out;
    logic [P_POS_W-1:0] r_pos_out;
    logic [7:0]         r_tx_data;
    logic               r_tx_wr;
    logic               r_active;
    logic               r_done;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_cs      <= '0;
            r_pos     <= '0;
            r_tmo     <= '0;
            r_is_hdr  <= 1'b0;
            r_cs_out  <= '0;
            r_pos_out <= '0;
            r_tx_data <= 8'h00;
            r_tx_wr   <= 1'b0;
            r_active  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_tx_wr <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_cs     <= '0;
                        r_pos    <= '0;
                        r_active <= 1'b1;
                        r_state  <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    r_tx_data <= HDR_BASE | 8'(r_cs);
                    r_is_hdr  <= 1'b1;
                    r_state   <= ST_SEND;
                end
                ST_ADDR: begin
                    r_cs_out  <= r_cs;
                    r_pos_out <= r_pos;
                    r_tmo     <= '0;
                    r_is_hdr  <= 1'b0;
                    r_state   <= ST_READ;
                end
                // A missing valid is replaced by a marker byte so the stream length never changes.
                ST_READ: begin
                    if (i_dmp_valid) begin
                        r_tx_data <= i_dmp_data;
                        r_state   <= ST_SEND;
                    end else if (r_tmo == TMO_LAST) begin
                        r_tx_data <= TIMEOUT_BYTE;
                        r_state   <= ST_SEND;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                ST_SEND: begin
                    if (!i_tx_busy) begin
                        r_tx_wr <= 1'b1;
                        r_state <= ST_GUARD;
                    end
                end
                // The transmitter raises busy one cycle after the write; skip that cycle.
                ST_GUARD: r_state <= ST_TXWAIT;
                ST_TXWAIT: begin
                    if (!i_tx_busy) begin
                        r_state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (r_is_hdr) begin
                        r_state <= ST_ADDR;
                    end else if (r_pos != POS_LAST) begin
                        r_pos   <= r_pos + P_POS_W'(1);
                        r_state <= ST_ADDR;
                    end else begin
                        r_pos <= '0;
                        if (r_cs != CS_LAST) begin
                            r_cs    <= r_cs + P_CS_W'(1);
                            r_state <= ST_HDR;
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_done   <= 1'b1;
                    r_active <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_cs      = r_cs_out;
    assign o_pos     = r_pos_out;
    assign o_tx_wr   = r_tx_wr;
    assign o_tx_data = r_tx_data;
    assign o_active  = r_active;
    assign o_done    = r_done;

endmodule

// File: tb/tb_dump_streamer.sv
// tb/tb_dump_streamer.sv - scoreboard bench for dump_streamer with CPU dump-port and UART models
module tb_dump_streamer;

    localparam int NC     = 2;
    localparam int DP     = 4;
    localparam int TMO    = 15;
    localparam int NBYTES = NC * (DP + 1);

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_start = 1'b0;
    logic [2:0] o_cs;
    logic [4:0] o_pos;
    logic [7:0] i_dmp_data = 8'h00;
    logic       i_dmp_valid = 1'b0;
    logic       o_tx_wr;
    logic [7:0] o_tx_data;
    logic       i_tx_busy = 1'b0;
    logic       o_active;
    logic       o_done;

    int total = 0;
    int bad   = 0;

    int cyc = 0, chg_cyc = 0, busy_cnt = 0;
    int wr_cnt = 0, done_cnt = 0, done_bad = 0, viol = 0;
    bit force_busy = 1'b0, miss_en = 1'b0, prev_wr = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] prev_addr = 8'h00;
    logic [7:0] got_q[$];
    int         lat_q[$];
    logic [7:0] exp_q[$];

    dump_streamer #(
        .P_CS_W(3), .P_POS_W(5), .P_NUM_CHIPS(NC), .P_DEPTH(DP), .P_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .i_rst(i_rst), .i_start(i_start),
        .o_cs(o_cs), .o_pos(o_pos),
        .i_dmp_data(i_dmp_data), .i_dmp_valid(i_dmp_valid),
        .o_tx_wr(o_tx_wr), .o_tx_data(o_tx_data), .i_tx_busy(i_tx_busy),
        .o_active(o_active), .o_done(o_done)
    );

    always #5 clk = ~clk;

    // CPU dump port, UART busy model and stream monitor, all evaluated mid-cycle.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if ({o_cs, o_pos} != prev_addr) begin
            chg_cyc   = cyc;
            prev_addr = {o_cs, o_pos};
        end
        i_dmp_data  = 8'(int'(o_cs) * 16 + int'(o_pos));
        i_dmp_valid = !(miss_en && o_cs == 3'd1 && o_pos == 5'd2);
        if (prev_wr && o_tx_data != prev_data) viol = viol + 1;
        if (o_tx_wr) begin
            got_q.push_back(o_tx_data);
            lat_q.push_back(cyc - chg_cyc);
            wr_cnt = wr_cnt + 1;
            if (prev_wr) viol = viol + 1;
            if (o_tx_data != prev_data) viol = viol + 1;
            busy_cnt = 10;
        end else if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
        end
        if (o_done) begin
            done_cnt = done_cnt + 1;
            if (o_active) done_bad = done_bad + 1;
        end
        i_tx_busy = force_busy || (busy_cnt != 0);
        prev_wr   = o_tx_wr;
        prev_data = o_tx_data;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_bench();
        got_q.delete();
        lat_q.delete();
        exp_q.delete();
        wr_cnt   = 0;
        done_cnt = 0;
        done_bad = 0;
    endtask

    task automatic start_dump(input bit miss);
        miss_en = miss;
        for (int c = 0; c < NC; c++) begin
            exp_q.push_back(8'hA0 | 8'(c));
            for (int p = 0; p < DP; p++)
                exp_q.push_back((miss && c == 1 && p == 2) ? 8'hFF : 8'(c * 16 + p));
        end
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_finished"}, int'(done_cnt != 0), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_count"}, got_q.size(), NBYTES);
        chk({tag, "_done_once"}, done_cnt, 1);
        chk({tag, "_active_fall"}, done_bad, 0);
        for (int i = 0; i < NBYTES; i++) begin
            if (got_q.size() == 0) begin
                chk($sformatf("%s_byte%0d_missing", tag, i), 0, 1);
                break;
            end
            chk($sformatf("%s_byte%0d", tag, i), got_q.pop_front(), exp_q.pop_front());
        end
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_active", o_active, 0);
        chk("rst_tx_wr", o_tx_wr, 0);
        chk("rst_done", o_done, 0);
        chk("rst_cs", o_cs, 0);
        chk("rst_pos", o_pos, 0);
        chk("rst_tx_data", o_tx_data, 0);

        // start coincident with reset must be dropped
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_rst   = 1'b0;
        @(negedge clk);
        chk("rst_wins_active", o_active, 0);
        repeat (20) @(negedge clk);
        chk("rst_wins_no_bytes", wr_cnt, 0);

        // plain dump
        clear_bench();
        start_dump(1'b0);
        chk("plain_active", o_active, 1);
        wait_done("plain");
        chk("plain_lat_c1p2", (lat_q.size() > 8) ? lat_q[8] : -1, 2);
        check_stream("plain");
        chk("plain_idle_cs", o_cs, 1);
        chk("plain_idle_pos", o_pos, DP - 1);

        // missing valid at cs=1,pos=2
        clear_bench();
        start_dump(1'b1);
        wait_done("miss");
        chk("miss_lat_c1p2", (lat_q.size() > 8) ? lat_q[8] : -1, TMO + 1);
        chk("miss_lat_c1p3", (lat_q.size() > 9) ? lat_q[9] : -1, 2);
        check_stream("miss");
        miss_en = 1'b0;

        // transmitter busy at start
        clear_bench();
        force_busy = 1'b1;
        start_dump(1'b0);
        repeat (200) @(negedge clk);
        chk("busy_no_wr", wr_cnt, 0);
        force_busy = 1'b0;
        wait_done("busy");
        check_stream("busy");

        // second start mid-dump is ignored
        clear_bench();
        start_dump(1'b0);
        n = 0;
        while (wr_cnt < 4 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("restart_reached_4", int'(wr_cnt >= 4), 1);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        wait_done("restart");
        repeat (100) @(negedge clk);
        chk("restart_no_requeue", wr_cnt, NBYTES);
        check_stream("restart");

        // reset mid-dump after third byte
        clear_bench();
        start_dump(1'b0);
        n = 0;
        while (wr_cnt < 3 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_reached_3", wr_cnt, 3);
        repeat (2) @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        chk("midrst_active", o_active, 0);
        chk("midrst_tx_wr", o_tx_wr, 0);
        i_rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("midrst_no_more_bytes", wr_cnt, 3);
        chk("midrst_no_done", done_cnt, 0);

        clear_bench();
        start_dump(1'b0);
        wait_done("after_rst");
        check_stream("after_rst");

        chk("protocol_violations", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
